vid_pattern_gen: RTL

//  Source end of the camera pixel interface (vsync/hsync/de + RGB565).

---
 rtl/vid_pattern_gen.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/vid_pattern_gen.sv
// -----------------------------------------------------------------------------
// vid_pattern_gen
//   Source end of the camera pixel interface. It produces raster timing
//   (vsync/hsync/de) and a selectable RGB565 test pattern, so the grey/filter
//   pipeline can be brought up and regressed without a real camera.
//   Only whole frames are produced. The run request and the pattern selection
//   are sampled when the counters sit at (0,0).
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   asynchronous, active-low reset
//   en           in   run request, sampled at frame start
//   pattern_sel  in   0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid
//   solid_rgb    in   RGB565 value used by the solid pattern
//   frame_vsync  out  vertical sync, active level given by SYNC_POL
//   frame_hsync  out  horizontal sync, active level given by SYNC_POL
//   frame_de     out  active-pixel strobe
//   frame_rgb    out  RGB565 pixel, 0 whenever frame_de is low
//   frame_start  out  one-clock pulse together with pixel (0,0)
// -----------------------------------------------------------------------------
module vid_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        frame_vsync,
    output logic        frame_hsync,
    output logic        frame_de,
    output logic [15:0] frame_rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BW      = H_ACTIVE / 8;
    localparam int BCW     = (BW > 1) ? $clog2(BW) : 1;

    localparam logic SYNC_ON  = 1'(SYNC_POL);
    localparam logic SYNC_OFF = ~SYNC_ON;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic [BCW-1:0]  bar_px;
    logic [2:0]      bar_idx;
    logic [1:0]      sel_q;
    logic [15:0]     solid_q;

    logic            at_start;
    logic            go;
    logic            h_last;
    logic            v_last;
    logic            active;
    logic            hsync_on;
    logic            vsync_on;
    logic [1:0]      cur_sel;
    logic [15:0]     cur_solid;
    logic [15:0]     bar_rgb;
    logic [5:0]      grey_hi;
    logic [15:0]     grey_rgb;
    logic            checker_on;
    logic [15:0]     pixel;

    // Counter decode and pattern selection for the current counter state.
    // At (0,0) the live inputs are used directly, because that is the very
    // cycle in which they are latched for the rest of the frame. An idle
    // block always sits at (0,0), so it restarts as soon as en is seen high.
    always_comb begin
        at_start   = (h_cnt == '0) && (v_cnt == '0);
        go         = at_start ? en : (state == RUN);
        cur_sel    = at_start ? pattern_sel : sel_q;
        cur_solid  = at_start ? solid_rgb : solid_q;
        h_last     = (h_cnt == HW'(H_TOTAL - 1));
        v_last     = (v_cnt == VW'(V_TOTAL - 1));
        active     = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        hsync_on   = (h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                     (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
        vsync_on   = (v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                     (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));

        case (bar_idx)
            3'd0:    bar_rgb = 16'hFFFF;
            3'd1:    bar_rgb = 16'hFFE0;
            3'd2:    bar_rgb = 16'h07FF;
            3'd3:    bar_rgb = 16'h07E0;
            3'd4:    bar_rgb = 16'hF81F;
            3'd5:    bar_rgb = 16'hF800;
            3'd6:    bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase

        // Grey level is x[7:0]. Only bits 7..2 reach the RGB565 fields.
        grey_hi    = 6'(h_cnt >> 2);
        grey_rgb   = {grey_hi[5:1], grey_hi, grey_hi[5:1]};
        checker_on = (((32'(h_cnt) ^ 32'(v_cnt)) >> 3) & 32'd1) != 32'd0;

        case (cur_sel)
            2'd0:    pixel = bar_rgb;
            2'd1:    pixel = grey_rgb;
            2'd2:    pixel = checker_on ? 16'hFFFF : 16'h0000;
            default: pixel = cur_solid;
        endcase
    end

    // Run/idle FSM, raster counters, bar tracker, pattern latch and
    // registered outputs. Every output is produced from the counter state
    // that exists before the clock edge, so all outputs stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_px      <= '0;
            bar_idx     <= '0;
            sel_q       <= '0;
            solid_q     <= '0;
            frame_vsync <= SYNC_OFF;
            frame_hsync <= SYNC_OFF;
            frame_de    <= 1'b0;
            frame_rgb   <= '0;
            frame_start <= 1'b0;
        end else if (go) begin
            state <= RUN;
            if (at_start) begin
                sel_q   <= pattern_sel;
                solid_q <= solid_rgb;
            end

            frame_de    <= active;
            frame_rgb   <= active ? pixel : 16'h0000;
            frame_hsync <= hsync_on ? SYNC_ON : SYNC_OFF;
            frame_vsync <= vsync_on ? SYNC_ON : SYNC_OFF;
            frame_start <= at_start;

            // The bar counter follows h_cnt in steps of BW pixels, which
            // avoids a divider. It restarts with every line.
            if (h_last) begin
                h_cnt   <= '0;
                v_cnt   <= v_last ? '0 : v_cnt + 1'b1;
                bar_px  <= '0;
                bar_idx <= '0;
            end else begin
                h_cnt <= h_cnt + 1'b1;
                if (bar_px == BCW'(BW - 1)) begin
                    bar_px  <= '0;
                    bar_idx <= bar_idx + 1'b1;
                end else begin
                    bar_px <= bar_px + 1'b1;
                end
            end
        end else begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_px      <= '0;
            bar_idx     <= '0;
            frame_vsync <= SYNC_OFF;
            frame_hsync <= SYNC_OFF;
            frame_de    <= 1'b0;
            frame_rgb   <= '0;
            frame_start <= 1'b0;
        end
    end

endmodule
